mem_ctrl: RTL and testbench

//  Byte-serial RAM controller upstream of the IF stage. Arbitrates instruction fetches (IF, on I-cache

---
 rtl/mem_ctrl_pkg.sv | 29 ++
 rtl/mem_ctrl.sv | 130 +++++++++++++
 tb/tb_mem_ctrl.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the byte-serial RAM controller: transfer sizes, FSM states,
// transaction kinds and the size-to-byte-count helper.
package mem_ctrl_pkg;

    localparam logic [1:0] SizeByte = 2'b00;
    localparam logic [1:0] SizeHalf = 2'b01;
    localparam logic [1:0] SizeWord = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    typedef enum logic {
        KindFetch = 1'b0,
        KindMem   = 1'b1
    } kind_t;

    // Encoding 2'b11 is treated as a full word.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SizeByte: size_bytes = 3'd1;
            SizeHalf: size_bytes = 3'd2;
            default:  size_bytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Arbitrates instruction fetches and data loads/stores onto one 8-bit synchronous
// RAM port, moving one byte per cycle and assembling little-endian words.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int RAM_AW = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [XLEN-1:0]   if_addr,
    input  logic              if_cancel,
    output logic [XLEN-1:0]   inst_o,
    output logic              inst_ok,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_size,
    input  logic [XLEN-1:0]   mem_addr,
    input  logic [XLEN-1:0]   mem_wdata,
    output logic [XLEN-1:0]   mem_rdata,
    output logic              mem_ok,
    input  logic [7:0]        ram_din,
    output logic [7:0]        ram_dout,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              ram_wr
);

    state_t          state, state_next;
    kind_t           kind;
    logic [XLEN-1:0] base;
    logic [XLEN-1:0] wdata;
    logic            we;
    logic [2:0]      n_bytes;
    logic [2:0]      cnt;
    logic [XLEN-1:0] lanes, lanes_next;
    logic            accept_mem, accept_fetch, fetch_abort, busy_last;

    // A redirected PC (address no longer matching the latched one) kills a fetch like a cancel.
    always_comb begin
        accept_mem   = (state == IDLE) && mem_req;
        accept_fetch = (state == IDLE) && !mem_req && if_req && !if_cancel;
        fetch_abort  = (state == BUSY) && (kind == KindFetch) && (if_cancel || (if_addr != base));
        busy_last    = (state == BUSY) && (we ? (cnt == n_bytes - 3'd1) : (cnt == n_bytes));

        state_next = state;
        case (state)
            IDLE: if (accept_mem || accept_fetch) state_next = BUSY;
            BUSY: begin
                if (fetch_abort)    state_next = IDLE;
                else if (busy_last) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Reads lag the address by one cycle, so byte cnt-1 arrives while cnt is being driven.
    always_comb begin
        ram_addr   = '0;
        ram_dout   = '0;
        ram_wr     = 1'b0;
        lanes_next = lanes;
        if ((state == BUSY) && (cnt < n_bytes)) begin
            ram_addr = base[RAM_AW-1:0] + RAM_AW'(cnt);
            ram_wr   = we;
            if (we) ram_dout = wdata[{cnt[1:0], 3'b000} +: 8];
        end
        if ((state == BUSY) && !we) begin
            case (cnt)
                3'd1:    lanes_next[7:0]   = ram_din;
                3'd2:    lanes_next[15:8]  = ram_din;
                3'd3:    lanes_next[23:16] = ram_din;
                3'd4:    lanes_next[31:24] = ram_din;
                default: lanes_next = lanes;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            kind      <= KindFetch;
            base      <= '0;
            wdata     <= '0;
            we        <= 1'b0;
            n_bytes   <= 3'd0;
            cnt       <= 3'd0;
            lanes     <= '0;
            inst_o    <= '0;
            mem_rdata <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (accept_mem) begin
                        kind    <= KindMem;
                        base    <= mem_addr;
                        we      <= mem_we;
                        n_bytes <= size_bytes(mem_size);
                        wdata   <= mem_wdata;
                        cnt     <= 3'd0;
                        lanes   <= '0;
                    end else if (accept_fetch) begin
                        kind    <= KindFetch;
                        base    <= if_addr;
                        we      <= 1'b0;
                        n_bytes <= 3'd4;
                        wdata   <= '0;
                        cnt     <= 3'd0;
                        lanes   <= '0;
                    end
                end
                BUSY: begin
                    cnt   <= cnt + 3'd1;
                    lanes <= lanes_next;
                    if (busy_last && !we && !fetch_abort) begin
                        if (kind == KindFetch) inst_o    <= lanes_next;
                        else                   mem_rdata <= lanes_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign inst_ok = (state == DONE) && (kind == KindFetch);
    assign mem_ok  = (state == DONE) && (kind == KindMem);

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: a table of single transactions plus cycle-exact
// sequences for arbitration, cancel, PC redirect and mid-store reset.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_cancel, mem_req, mem_we;
    logic [31:0] if_addr, mem_addr, mem_wdata;
    logic [1:0]  mem_size;
    logic [31:0] inst_o, mem_rdata;
    logic        inst_ok, mem_ok, ram_wr;
    logic [7:0]  ram_din, ram_dout;
    logic [16:0] ram_addr;

    logic [7:0]  ram [0:131071];

    int errCount   = 0;
    int checkCount = 0;

    typedef struct {
        string       name;
        logic        isFetch;
        logic        we;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        cancel;
        logic [31:0] expData;
        int          expLat;
    } vec_t;

    vec_t vecs[10];

    mem_ctrl #(.XLEN(32), .RAM_AW(17)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_cancel(if_cancel),
        .inst_o(inst_o), .inst_ok(inst_ok),
        .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ok(mem_ok),
        .ram_din(ram_din), .ram_dout(ram_dout), .ram_addr(ram_addr), .ram_wr(ram_wr)
    );

    always #5 clk = ~clk;

    // Synchronous byte RAM: data appears the cycle after the address.
    always @(posedge clk) begin
        ram_din <= ram[ram_addr];
        if (ram_wr) ram[ram_addr] <= ram_dout;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    function automatic logic [31:0] ramWord(input logic [16:0] a);
        logic [16:0] a1, a2, a3;
        a1 = a + 17'd1;
        a2 = a + 17'd2;
        a3 = a + 17'd3;
        return {ram[a3], ram[a2], ram[a1], ram[a]};
    endfunction

    task automatic idleInputs();
        if_req = 0; if_cancel = 0; mem_req = 0; mem_we = 0;
        mem_size = 2'b00; if_addr = 0; mem_addr = 0; mem_wdata = 0;
    endtask

    // Issues one transaction, holds the request through the ok cycle, returns latency and data.
    task automatic applyStimulus(input vec_t v, output int lat, output logic [31:0] data, output logic wrongOk);
        lat = -1; data = 0; wrongOk = 0;
        if (v.isFetch) begin
            if_req = 1; if_addr = v.addr;
        end else begin
            mem_req = 1; mem_we = v.we; mem_size = v.size; mem_addr = v.addr; mem_wdata = v.wdata;
            if_cancel = v.cancel;
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if ((v.isFetch && mem_ok) || (!v.isFetch && inst_ok)) wrongOk = 1;
            if ((v.isFetch && inst_ok) || (!v.isFetch && mem_ok)) begin
                lat = c;
                data = v.isFetch ? inst_o : mem_rdata;
            end
            tick();
            if (lat >= 0) break;
        end
        idleInputs();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int          lat;
        logic [31:0] data;
        logic        wrongOk;

        for (int i = 0; i < 131072; i++) ram[i] = 8'h00;
        {ram[17'h103], ram[17'h102], ram[17'h101], ram[17'h100]} = 32'h00000513;
        {ram[17'h203], ram[17'h202], ram[17'h201], ram[17'h200]} = 32'h000012b7;
        {ram[17'h303], ram[17'h302], ram[17'h301], ram[17'h300]} = 32'h00100093;
        {ram[17'h043], ram[17'h042], ram[17'h041], ram[17'h040]} = 32'h44332211;
        {ram[17'h051], ram[17'h050]} = 16'hABCD;
        {ram[17'h063], ram[17'h062], ram[17'h061], ram[17'h060]} = 32'hEEEEEEEE;
        ram[17'h007]   = 8'h81;
        ram[17'h1FFFF] = 8'hAA;
        ram[17'h00000] = 8'h55;

        vecs[0] = '{"fetch_word",     1, 0, 2'b10, 32'h100,      32'h0,        0, 32'h00000513, 6};
        vecs[1] = '{"load_word",      0, 0, 2'b10, 32'h40,       32'h0,        0, 32'h44332211, 6};
        vecs[2] = '{"load_byte",      0, 0, 2'b00, 32'h7,        32'h0,        0, 32'h00000081, 3};
        vecs[3] = '{"load_half",      0, 0, 2'b01, 32'h50,       32'h0,        0, 32'h0000ABCD, 4};
        vecs[4] = '{"load_size3",     0, 0, 2'b11, 32'h40,       32'h0,        0, 32'h44332211, 6};
        vecs[5] = '{"load_half_wrap", 0, 0, 2'b01, 32'h1FFFF,    32'h0,        0, 32'h000055AA, 4};
        vecs[6] = '{"load_hi_addr",   0, 0, 2'b00, 32'hFFFE0007, 32'h0,        1, 32'h00000081, 3};
        vecs[7] = '{"store_word",     0, 1, 2'b10, 32'h20,       32'hDEADBEEF, 0, 32'hDEADBEEF, 5};
        vecs[8] = '{"store_byte",     0, 1, 2'b00, 32'h60,       32'h12345678, 0, 32'hEEEEEE78, 2};
        vecs[9] = '{"store_half",     0, 1, 2'b01, 32'h70,       32'hCAFEBABE, 1, 32'h0000BABE, 3};

        idleInputs();
        rst = 1;
        tick(); tick();
        @(negedge clk);
        checkOutput("reset_inst_o",    inst_o,           32'h0);
        checkOutput("reset_mem_rdata", mem_rdata,        32'h0);
        checkOutput("reset_ram_addr",  {15'h0, ram_addr}, 32'h0);
        checkOutput("reset_ram_dout",  {24'h0, ram_dout}, 32'h0);
        checkOutput("reset_oks",       {30'h0, inst_ok, mem_ok}, 32'h0);
        checkOutput("reset_ram_wr",    {31'h0, ram_wr},  32'h0);
        tick();
        rst = 0;
        tick();

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i], lat, data, wrongOk);
            checkOutput({vecs[i].name, "_latency"}, lat, vecs[i].expLat);
            checkOutput({vecs[i].name, "_other_ok"}, {31'h0, wrongOk}, 32'h0);
            if (vecs[i].we) checkOutput({vecs[i].name, "_ram"}, ramWord(vecs[i].addr[16:0]), vecs[i].expData);
            else            checkOutput({vecs[i].name, "_data"}, data, vecs[i].expData);
            tick();
        end

        // Fetch timing: address walk and single-cycle inst_ok.
        $display("[TB] fetch timing sequence");
        if_req = 1; if_addr = 32'h100;
        for (int c = 0; c < 8; c++) begin
            if (c == 7) if_req = 0;
            @(negedge clk);
            checkOutput($sformatf("t1_inst_ok_c%0d", c), {31'h0, inst_ok}, {31'h0, c == 6});
            if (c >= 1 && c <= 4) begin
                checkOutput($sformatf("t1_ram_addr_c%0d", c), {15'h0, ram_addr}, 32'h100 + c - 1);
                checkOutput($sformatf("t1_ram_wr_c%0d", c), {31'h0, ram_wr}, 32'h0);
            end
            if (c == 6) checkOutput("t1_inst_o", inst_o, 32'h00000513);
            tick();
        end
        idleInputs();

        // Simultaneous requests: data side wins, fetch waits.
        $display("[TB] arbitration sequence");
        if_req = 1; if_addr = 32'h200;
        mem_req = 1; mem_we = 0; mem_size = 2'b10; mem_addr = 32'h40;
        for (int c = 0; c < 15; c++) begin
            if (c == 7)  mem_req = 0;
            if (c == 14) if_req = 0;
            @(negedge clk);
            checkOutput($sformatf("t2_mem_ok_c%0d", c),  {31'h0, mem_ok},  {31'h0, c == 6});
            checkOutput($sformatf("t2_inst_ok_c%0d", c), {31'h0, inst_ok}, {31'h0, c == 13});
            tick();
        end
        checkOutput("t2_mem_rdata", mem_rdata, 32'h44332211);
        checkOutput("t2_inst_o",    inst_o,    32'h000012b7);
        idleInputs();

        // Word store: strobe, address and data bytes per cycle.
        $display("[TB] store timing sequence");
        begin
            logic [31:0] storeWord;
            storeWord = 32'hDEADBEEF;
            mem_req = 1; mem_we = 1; mem_size = 2'b10; mem_addr = 32'h20; mem_wdata = storeWord;
            for (int c = 0; c < 7; c++) begin
                if (c == 6) mem_req = 0;
                @(negedge clk);
                checkOutput($sformatf("t3_ram_wr_c%0d", c), {31'h0, ram_wr}, {31'h0, c >= 1 && c <= 4});
                checkOutput($sformatf("t3_mem_ok_c%0d", c), {31'h0, mem_ok}, {31'h0, c == 5});
                if (c >= 1 && c <= 4) begin
                    checkOutput($sformatf("t3_ram_addr_c%0d", c), {15'h0, ram_addr}, 32'h20 + c - 1);
                    checkOutput($sformatf("t3_ram_dout_c%0d", c), {24'h0, ram_dout}, {24'h0, storeWord[8*(c-1) +: 8]});
                end
                tick();
            end
        end
        idleInputs();

        // Fetch offered with if_cancel already high is not taken that cycle.
        $display("[TB] cancel-at-request sequence");
        if_req = 1; if_addr = 32'h300; if_cancel = 1;
        for (int c = 0; c < 9; c++) begin
            if (c == 1) if_cancel = 0;
            if (c == 8) if_req = 0;
            @(negedge clk);
            checkOutput($sformatf("t4_inst_ok_c%0d", c), {31'h0, inst_ok}, {31'h0, c == 7});
            tick();
        end
        idleInputs();

        // Cancel during a fetch, then a new fetch from the redirected PC.
        $display("[TB] cancel sequence");
        if_req = 1; if_addr = 32'h100;
        for (int c = 0; c < 12; c++) begin
            if (c == 3) if_cancel = 1;
            if (c == 4) begin if_cancel = 0; if_addr = 32'h300; end
            if (c == 11) if_req = 0;
            @(negedge clk);
            checkOutput($sformatf("t5_inst_ok_c%0d", c), {31'h0, inst_ok}, {31'h0, c == 10});
            if (c == 4) checkOutput("t5_idle_ram_addr", {15'h0, ram_addr}, 32'h0);
            tick();
        end
        checkOutput("t5_inst_o", inst_o, 32'h00100093);
        idleInputs();

        // PC change without cancel aborts the in-flight fetch.
        $display("[TB] redirect sequence");
        if_req = 1; if_addr = 32'h100;
        for (int c = 0; c < 11; c++) begin
            if (c == 2) if_addr = 32'h200;
            if (c == 10) if_req = 0;
            @(negedge clk);
            checkOutput($sformatf("t7_inst_ok_c%0d", c), {31'h0, inst_ok}, {31'h0, c == 9});
            tick();
        end
        checkOutput("t7_inst_o", inst_o, 32'h000012b7);
        idleInputs();

        // Reset in the middle of a word store.
        $display("[TB] reset-mid-store sequence");
        mem_req = 1; mem_we = 1; mem_size = 2'b10; mem_addr = 32'h90; mem_wdata = 32'h11223344;
        for (int c = 0; c < 9; c++) begin
            if (c == 1) mem_req = 0;
            if (c == 2) rst = 1;
            if (c == 3) rst = 0;
            @(negedge clk);
            checkOutput($sformatf("t6_mem_ok_c%0d", c), {31'h0, mem_ok}, 32'h0);
            if (c >= 3) checkOutput($sformatf("t6_ram_wr_c%0d", c), {31'h0, ram_wr}, 32'h0);
            tick();
        end
        idleInputs();
        checkOutput("t6_partial_ram", ramWord(17'h90), 32'h00003344);
        applyStimulus(vecs[1], lat, data, wrongOk);
        checkOutput("t6_after_load_lat",  lat,  32'd6);
        checkOutput("t6_after_load_data", data, 32'h44332211);
        tick();

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
